dmem_responder: RTL

//  Memory-side responder for the CPU data-memory port. Accepts one load/store

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory-side responder for the CPU data-memory port. It accepts
//             one load or store at a time and completes it after a fixed
//             latency. The result is returned on a valid/ready response
//             channel.
//  Ports    : clk, reset (sync, active-low)
//             req_valid/req_ready, req_addr, req_we, req_re, req_wdata
//             resp_valid/resp_ready, resp_rdata, resp_err
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_we,
   input  logic              req_re,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int CNT_W = $clog2(LATENCY) + 1;
   localparam int IDX_W = $clog2(DEPTH);
   // One extra bit so the byte-size limit cannot overflow the address width.
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * 4);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [CNT_W-1:0]    counter;
   logic [ADDR_W-1:0]   lat_addr;
   logic                lat_we;
   logic                lat_re;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                accept;
   logic                access;
   logic                bad_req;
   logic [IDX_W-1:0]    word_idx;

   // The latched request is illegal if it is misaligned or out of range. It
   // is also illegal unless exactly one of load/store is set.
   assign bad_req  = (lat_addr[1:0] != 2'b00)
                   || ({1'b0, lat_addr} >= ADDR_LIMIT)
                   || (lat_we == lat_re);
   assign word_idx = lat_addr[IDX_W+1:2];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      access     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = reset;
            accept    = reset && req_valid;
            if (accept) begin
               next_state = BUSY;
            end
         end
         BUSY: begin
            if (counter == '0) begin
               access     = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            // Returning to IDLE here means a new request can only be
            // accepted in the cycle after the response handshake.
            if (resp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!reset) begin
         counter    <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            lat_addr  <= req_addr;
            lat_we    <= req_we;
            lat_re    <= req_re;
            lat_wdata <= req_wdata;
            counter   <= CNT_W'(LATENCY - 1);
         end else if (state == BUSY && counter != '0) begin
            counter <= counter - CNT_W'(1);
         end

         if (access) begin
            if (bad_req) begin
               resp_rdata <= '0;
               resp_err   <= 1'b1;
            end else if (lat_re) begin
               resp_rdata <= mem[word_idx];
               resp_err   <= 1'b0;
            end else begin
               resp_rdata <= '0;
               resp_err   <= 1'b0;
            end
         end
      end
   end

   // Storage has no reset, so its contents survive reset. The write is
   // qualified by reset so a store interrupted by reset never lands.
   always_ff @(posedge clk) begin
      if (reset && access && !bad_req && lat_we) begin
         mem[word_idx] <= lat_wdata;
      end
   end

endmodule
`default_nettype wire
